// File: rtl/instructions_pkg.sv
// Shared architectural types for the single-cycle core and the blocks
// that feed it.
package instructions_pkg;

    // One architectural register / memory word.
    typedef logic [31:0] arch_reg;

endpackage

// File: rtl/loader_pkg.sv
// Types shared by the instruction-memory loader.
package loader_pkg;

    // Loader FSM. The encoding is fixed so that waveforms read the same
    // across tools.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Program loader for the single-cycle core. Streams instruction words
// from a valid/ready source into the core's setup port at consecutive
// word addresses, holding the core in reset until the last write has
// been presented, then lets the core run.
module imem_loader
    import instructions_pkg::*;
    import loader_pkg::*;
#(
    parameter arch_reg BASE_ADDR = 32'h0000_0000,
    parameter int      MAX_WORDS = 1024
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    start,
    input  arch_reg word_count,
    input  logic    in_valid,
    input  arch_reg in_data,
    output logic    in_ready,
    output logic    setup_write,
    output arch_reg setup_address,
    output arch_reg setup_data_in,
    output logic    core_reset,
    output logic    busy,
    output logic    done,
    output logic    error
);

    localparam int REM_W = $clog2(MAX_WORDS + 1);

    loader_state_t    state;
    loader_state_t    state_next;
    logic [REM_W-1:0] remaining;
    arch_reg          addr;
    logic             count_legal;
    logic             start_seen;
    logic             handshake;

    // The full 32-bit count is compared, so large values whose low bits
    // happen to look small are still rejected.
    assign count_legal = (word_count != '0) && (word_count <= arch_reg'(MAX_WORDS));
    assign start_seen  = start && ((state == IDLE) || (state == RUN));
    assign in_ready    = (state == LOAD);
    assign handshake   = in_valid && in_ready;
    assign busy        = (state == LOAD) || (state == FLUSH);
    assign done        = (state == RUN);

    // Next-state decode; start is only honoured in IDLE and RUN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, RUN: begin
                if (start) begin
                    state_next = count_legal ? LOAD : IDLE;
                end
            end
            LOAD: begin
                if (handshake && (remaining == REM_W'(1))) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                state_next = RUN;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; core_reset is registered from the next state so it
    // drops exactly when RUN is entered and rises as soon as LOAD begins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            core_reset <= 1'b1;
        end else begin
            state      <= state_next;
            core_reset <= (state_next != RUN);
        end
    end

    // Address and remaining-word counters. The address never wraps because
    // the parameters keep the last word inside 32 bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            remaining <= '0;
            addr      <= BASE_ADDR;
        end else if (start_seen && count_legal) begin
            remaining <= word_count[REM_W-1:0];
            addr      <= BASE_ADDR;
        end else if (handshake) begin
            remaining <= remaining - REM_W'(1);
            addr      <= addr + 32'd4;
        end
    end

    // Setup-port registers: one strobe per accepted word, address and data
    // hold their previous values between writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            setup_write   <= 1'b0;
            setup_address <= BASE_ADDR;
            setup_data_in <= '0;
        end else begin
            setup_write <= handshake;
            if (handshake) begin
                setup_address <= addr;
                setup_data_in <= in_data;
            end
        end
    end

    // Sticky error flag, updated only when a start is actually considered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            error <= 1'b0;
        end else if (start_seen) begin
            error <= !count_legal;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader. Expected writes are queued when a
// word is driven and checked by a monitor when the write strobe appears.
module tb_imem_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] word_count;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        setup_write;
    logic [31:0] setup_address;
    logic [31:0] setup_data_in;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [63:0] mon_entry;

    imem_loader #(
        .BASE_ADDR(32'h0000_0000),
        .MAX_WORDS(1024)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .word_count(word_count),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .setup_write(setup_write),
        .setup_address(setup_address),
        .setup_data_in(setup_data_in),
        .core_reset(core_reset),
        .busy(busy),
        .done(done),
        .error(error)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_bit(input string tag, input logic actual, input logic expected);
        checks++;
        assert (actual === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, actual, expected);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        assert (actual === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // Drive one stream word for one cycle and queue the write it must cause.
    task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] data);
        in_valid = 1'b1;
        in_data  = data;
        exp_q.push_back({addr, data});
        cycle();
    endtask

    // Issue a start pulse for one edge.
    task automatic issue_start(input logic [31:0] count);
        start      = 1'b1;
        word_count = count;
        cycle();
        start      = 1'b0;
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clock) begin
        if (!reset && setup_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_bit("unexpected_write", setup_write, 1'b0);
            end else begin
                mon_entry = exp_q.pop_front();
                check_word("write_addr", setup_address, mon_entry[63:32]);
                check_word("write_data", setup_data_in, mon_entry[31:0]);
            end
        end
    end

    initial begin
        logic [6:0]  pattern;
        logic [31:0] next_addr;
        logic [31:0] last_addr;

        reset      = 1'b0;
        start      = 1'b0;
        word_count = '0;
        in_valid   = 1'b0;
        in_data    = '0;

        // Asynchronous reset asserted between clock edges.
        #2 reset = 1'b1;
        #1;
        check_bit("rst_core_reset", core_reset, 1'b1);
        check_bit("rst_setup_write", setup_write, 1'b0);
        check_word("rst_setup_address", setup_address, 32'h0);
        check_word("rst_setup_data", setup_data_in, 32'h0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_error", error, 1'b0);
        check_bit("rst_in_ready", in_ready, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        cycle();
        reset = 1'b0;
        cycle();
        check_bit("idle_in_ready", in_ready, 1'b0);

        // Basic three-word load.
        issue_start(32'd3);
        check_bit("basic_in_ready", in_ready, 1'b1);
        check_bit("basic_busy", busy, 1'b1);
        check_bit("basic_core_reset_load", core_reset, 1'b1);
        apply_stimulus(32'h0, 32'h0050_0093);
        apply_stimulus(32'h4, 32'h00A0_0113);
        apply_stimulus(32'h8, 32'h0020_81B3);
        in_valid = 1'b0;
        check_bit("flush_setup_write", setup_write, 1'b1);
        check_bit("flush_core_reset", core_reset, 1'b1);
        check_bit("flush_in_ready", in_ready, 1'b0);
        check_bit("flush_busy", busy, 1'b1);
        cycle();
        check_bit("run_core_reset", core_reset, 1'b0);
        check_bit("run_done", done, 1'b1);
        check_bit("run_setup_write", setup_write, 1'b0);
        check_bit("run_busy", busy, 1'b0);
        check_word("basic_queue_empty", 32'(exp_q.size()), 32'd0);

        // Four-word load from RUN with a gappy valid pattern 1,0,0,1,1,0,1.
        issue_start(32'd4);
        check_bit("bp_core_reset", core_reset, 1'b1);
        check_bit("bp_done", done, 1'b0);
        pattern   = 7'b1011001;
        next_addr = 32'h0;
        last_addr = 32'h0;
        for (int i = 0; i < 7; i++) begin
            in_valid = pattern[i];
            in_data  = 32'hA000_0000 + 32'(i);
            if (pattern[i]) begin
                exp_q.push_back({next_addr, in_data});
                last_addr = next_addr;
                next_addr = next_addr + 32'd4;
            end
            cycle();
            check_bit("bp_write_strobe", setup_write, pattern[i]);
            if (!pattern[i]) begin
                check_word("bp_addr_hold", setup_address, last_addr);
            end
        end
        in_valid = 1'b0;
        check_bit("bp_flush_busy", busy, 1'b1);
        cycle();
        check_bit("bp_run_done", done, 1'b1);
        check_bit("bp_run_core_reset", core_reset, 1'b0);
        check_word("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Illegal counts: zero from RUN, then MAX_WORDS+1, then a value whose
        // low bits alone would look legal.
        issue_start(32'd0);
        check_bit("ill0_error", error, 1'b1);
        check_bit("ill0_done", done, 1'b0);
        check_bit("ill0_busy", busy, 1'b0);
        check_bit("ill0_core_reset", core_reset, 1'b1);
        check_bit("ill0_in_ready", in_ready, 1'b0);
        cycle();
        check_bit("ill0_sticky", error, 1'b1);
        check_bit("ill0_no_write", setup_write, 1'b0);
        issue_start(32'd1025);
        check_bit("ill1025_error", error, 1'b1);
        check_bit("ill1025_busy", busy, 1'b0);
        check_bit("ill1025_core_reset", core_reset, 1'b1);
        issue_start(32'h0001_0003);
        check_bit("illhigh_error", error, 1'b1);
        check_bit("illhigh_busy", busy, 1'b0);

        // MAX_WORDS is legal and clears the error; abort it with a reset.
        issue_start(32'd1024);
        check_bit("max_error_clear", error, 1'b0);
        check_bit("max_busy", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_bit("max_rst_busy", busy, 1'b0);
        check_bit("max_rst_in_ready", in_ready, 1'b0);
        cycle();
        reset = 1'b0;
        cycle();

        // Reset after two handshakes of a four-word load.
        issue_start(32'd4);
        apply_stimulus(32'h0, 32'hB000_0000);
        in_valid = 1'b1;
        in_data  = 32'hB000_0001;
        cycle();
        in_valid = 1'b0;
        check_bit("mid_write_live", setup_write, 1'b1);
        check_word("mid_write_addr", setup_address, 32'h4);
        #1 reset = 1'b1;
        #1;
        check_bit("mid_rst_write", setup_write, 1'b0);
        check_bit("mid_rst_core_reset", core_reset, 1'b1);
        check_bit("mid_rst_in_ready", in_ready, 1'b0);
        check_word("mid_rst_addr", setup_address, 32'h0);
        cycle();
        reset = 1'b0;
        cycle();
        check_bit("post_rst_no_write", setup_write, 1'b0);
        check_bit("post_rst_busy", busy, 1'b0);
        issue_start(32'd2);
        apply_stimulus(32'h0, 32'hC000_0000);
        apply_stimulus(32'h4, 32'hC000_0001);
        in_valid = 1'b0;
        cycle();
        check_bit("fresh_run_done", done, 1'b1);
        check_word("fresh_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reload a single word from RUN.
        issue_start(32'd1);
        check_bit("reload_core_reset", core_reset, 1'b1);
        check_bit("reload_done", done, 1'b0);
        check_bit("reload_in_ready", in_ready, 1'b1);
        apply_stimulus(32'h0, 32'h0000_0013);
        in_valid = 1'b0;
        check_bit("reload_flush_write", setup_write, 1'b1);
        cycle();
        check_bit("reload_run_core_reset", core_reset, 1'b0);
        check_bit("reload_run_done", done, 1'b1);
        cycle();
        cycle();
        check_bit("final_no_write", setup_write, 1'b0);
        check_word("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
